// File: rtl/vpg_timing_pkg.sv
// Shared video pattern generator definitions: mode codes, the per-mode raster
// timing record, the mode -> timing lookup, and the timing FSM state type.
//
// Contents:
//   vpg_mode_e      mode codes shared with the mode selector
//   vpg_timing_t    eight VPG_CNT_W raster fields plus sync polarities
//                   (polarity 1 = sync is active-high)
//   vpg_lookup()    mode code -> timing record; unknown codes map to VGA
//   vpg_max_total() largest H or V total over every 4-bit code
package vpg_timing_pkg;

    localparam int VPG_CNT_W = 12;

    typedef enum logic [3:0] {
        VGA_640x480p60    = 4'd0,
        SVGA_800x600p60   = 4'd1,
        XGA_1024x768p60   = 4'd2,
        HD_1280x720p60    = 4'd3,
        FHD_1920x1080p60  = 4'd4,
        VESA_1600x1200p60 = 4'd5
    } vpg_mode_e;

    typedef struct packed {
        logic [VPG_CNT_W-1:0] h_act;
        logic [VPG_CNT_W-1:0] h_fp;
        logic [VPG_CNT_W-1:0] h_sync;
        logic [VPG_CNT_W-1:0] h_bp;
        logic [VPG_CNT_W-1:0] v_act;
        logic [VPG_CNT_W-1:0] v_fp;
        logic [VPG_CNT_W-1:0] v_sync;
        logic [VPG_CNT_W-1:0] v_bp;
        logic                 h_pol;
        logic                 v_pol;
    } vpg_timing_t;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_RUN    = 1'b1
    } vpg_state_e;

    function automatic vpg_timing_t vpg_mk(input int ha, input int hf, input int hsy, input int hb,
                                           input int va, input int vf, input int vsy, input int vb,
                                           input logic hp, input logic vp);
        vpg_timing_t t;
        t.h_act  = VPG_CNT_W'(ha);
        t.h_fp   = VPG_CNT_W'(hf);
        t.h_sync = VPG_CNT_W'(hsy);
        t.h_bp   = VPG_CNT_W'(hb);
        t.v_act  = VPG_CNT_W'(va);
        t.v_fp   = VPG_CNT_W'(vf);
        t.v_sync = VPG_CNT_W'(vsy);
        t.v_bp   = VPG_CNT_W'(vb);
        t.h_pol  = hp;
        t.v_pol  = vp;
        return t;
    endfunction

    function automatic vpg_timing_t vpg_lookup(input logic [3:0] mode);
        vpg_timing_t t;
        case (mode)
            SVGA_800x600p60:   t = vpg_mk( 800, 40, 128,  88,  600, 1, 4, 23, 1'b1, 1'b1);
            XGA_1024x768p60:   t = vpg_mk(1024, 24, 136, 160,  768, 3, 6, 29, 1'b0, 1'b0);
            HD_1280x720p60:    t = vpg_mk(1280,110,  40, 220,  720, 5, 5, 20, 1'b1, 1'b1);
            FHD_1920x1080p60:  t = vpg_mk(1920, 88,  44, 148, 1080, 4, 5, 36, 1'b1, 1'b1);
            VESA_1600x1200p60: t = vpg_mk(1600, 64, 192, 304, 1200, 1, 3, 46, 1'b1, 1'b1);
            default:           t = vpg_mk( 640, 16,  96,  48,  480,10, 2, 33, 1'b0, 1'b0);
        endcase
        return t;
    endfunction

    function automatic int vpg_max_total();
        vpg_timing_t t;
        int          tot;
        int          m_max;
        m_max = 0;
        for (int m = 0; m < 16; m++) begin
            t   = vpg_lookup(4'(m));
            tot = int'(t.h_act) + int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
            if (tot > m_max) m_max = tot;
            tot = int'(t.v_act) + int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
            if (tot > m_max) m_max = tot;
        end
        return m_max;
    endfunction

endpackage

// File: rtl/vpg_timing_lut.sv
// Combinational mode -> raster timing lookup, fed from the latched mode register.
//
// Ports:
//   i_mode    mode code (unknown codes give VGA 640x480p60 timing)
//   o_timing  raster parameters and sync polarities for i_mode
module vpg_timing_lut
    import vpg_timing_pkg::*;
(
    input  logic [3:0]  i_mode,
    output vpg_timing_t o_timing
);

    assign o_timing = vpg_lookup(i_mode);

endmodule

// File: rtl/vpg_timing.sv
// Video timing generator: raster counters, sync, data-enable and frame marker
// for the currently selected mode. Every mode change blanks the outputs for a
// settle interval and then restarts the raster at pixel (0,0).
//
// Ports:
//   clk              pixel clock
//   reset_n          asynchronous active-low reset
//   clk_en           advance enable; nothing changes while low
//   vpg_mode_change  one-cycle strobe from the mode selector
//   vpg_mode         mode code, sampled with the strobe
//   hs, vs           syncs at the mode's polarity
//   de               active-video enable
//   x, y             active pixel column / line, 0 outside the active area
//   frame_start      one-cycle pulse for h=0, v=0
//   busy             high while settling
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_SETTLE | outputs blanked, settle counter runs to SETTLE_CYCLES-1
// ST_RUN    | h/v raster counters run, outputs decoded from them
module vpg_timing
    import vpg_timing_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1024,
    parameter int CNT_W         = 12
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_en,
    input  logic             vpg_mode_change,
    input  logic [3:0]       vpg_mode,
    output logic             hs,
    output logic             vs,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             frame_start,
    output logic             busy
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam vpg_timing_t RST_T = vpg_lookup(VESA_1600x1200p60);

    // Totals must stay strictly below 2**CNT_W so sync-end and total sums never wrap.
    if (SETTLE_CYCLES < 1) begin : g_chk_settle
        $error("vpg_timing: SETTLE_CYCLES must be at least 1");
    end
    if (CNT_W > 30 || vpg_max_total() >= (1 << CNT_W)) begin : g_chk_cnt_w
        $error("vpg_timing: CNT_W too narrow for the largest mode total");
    end

    vpg_state_e       r_state;
    logic [SET_W-1:0] r_settle_cnt;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic [3:0]       r_mode;
    logic             r_hs;
    logic             r_vs;
    logic             r_de;
    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic             r_fs;
    logic             r_busy;

    vpg_state_e       w_state_nxt;
    logic [SET_W-1:0] w_settle_nxt;
    logic [CNT_W-1:0] w_h_nxt;
    logic [CNT_W-1:0] w_v_nxt;
    logic [3:0]       w_mode_nxt;
    logic             w_hs_nxt;
    logic             w_vs_nxt;
    logic             w_de_nxt;
    logic [CNT_W-1:0] w_x_nxt;
    logic [CNT_W-1:0] w_y_nxt;
    logic             w_fs_nxt;
    logic             w_busy_nxt;

    vpg_timing_t      w_t;
    logic [CNT_W-1:0] w_h_act;
    logic [CNT_W-1:0] w_h_sync_start;
    logic [CNT_W-1:0] w_h_sync_end;
    logic [CNT_W-1:0] w_h_last;
    logic [CNT_W-1:0] w_v_act;
    logic [CNT_W-1:0] w_v_sync_start;
    logic [CNT_W-1:0] w_v_sync_end;
    logic [CNT_W-1:0] w_v_last;

    vpg_timing_lut u_lut (
        .i_mode   (r_mode),
        .o_timing (w_t)
    );

    assign w_h_act        = CNT_W'(w_t.h_act);
    assign w_h_sync_start = CNT_W'(w_t.h_act) + CNT_W'(w_t.h_fp);
    assign w_h_sync_end   = w_h_sync_start + CNT_W'(w_t.h_sync);
    assign w_h_last       = w_h_sync_end + CNT_W'(w_t.h_bp) - CNT_W'(1);
    assign w_v_act        = CNT_W'(w_t.v_act);
    assign w_v_sync_start = CNT_W'(w_t.v_act) + CNT_W'(w_t.v_fp);
    assign w_v_sync_end   = w_v_sync_start + CNT_W'(w_t.v_sync);
    assign w_v_last       = w_v_sync_end + CNT_W'(w_t.v_bp) - CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_SETTLE;
            r_settle_cnt <= '0;
            r_h          <= '0;
            r_v          <= '0;
            r_mode       <= VESA_1600x1200p60;
            r_hs         <= ~RST_T.h_pol;
            r_vs         <= ~RST_T.v_pol;
            r_de         <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_fs         <= 1'b0;
            r_busy       <= 1'b1;
        end else if (clk_en) begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_h          <= w_h_nxt;
            r_v          <= w_v_nxt;
            r_mode       <= w_mode_nxt;
            r_hs         <= w_hs_nxt;
            r_vs         <= w_vs_nxt;
            r_de         <= w_de_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_fs         <= w_fs_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle_cnt;
        w_h_nxt      = r_h;
        w_v_nxt      = r_v;
        w_mode_nxt   = r_mode;
        w_hs_nxt     = ~w_t.h_pol;
        w_vs_nxt     = ~w_t.v_pol;
        w_de_nxt     = 1'b0;
        w_x_nxt      = '0;
        w_y_nxt      = '0;
        w_fs_nxt     = 1'b0;
        w_busy_nxt   = 1'b1;

        // Outputs decode the counters as they stood before this edge.
        if (r_state == ST_RUN) begin
            w_de_nxt   = (r_h < w_h_act) && (r_v < w_v_act);
            w_hs_nxt   = ((r_h >= w_h_sync_start) && (r_h < w_h_sync_end)) ? w_t.h_pol : ~w_t.h_pol;
            w_vs_nxt   = ((r_v >= w_v_sync_start) && (r_v < w_v_sync_end)) ? w_t.v_pol : ~w_t.v_pol;
            w_x_nxt    = w_de_nxt ? r_h : '0;
            w_y_nxt    = w_de_nxt ? r_v : '0;
            w_fs_nxt   = (r_h == '0) && (r_v == '0);
            w_busy_nxt = 1'b0;
        end

        case (r_state)
            ST_SETTLE: begin
                if (r_settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
                    w_state_nxt = ST_RUN;
                    w_h_nxt     = '0;
                    w_v_nxt     = '0;
                end else begin
                    w_settle_nxt = r_settle_cnt + SET_W'(1);
                end
            end
            ST_RUN: begin
                if (r_h == w_h_last) begin
                    w_h_nxt = '0;
                    w_v_nxt = (r_v == w_v_last) ? '0 : r_v + CNT_W'(1);
                end else begin
                    w_h_nxt = r_h + CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_SETTLE;
        endcase

        // A strobe overrides everything, blanking on this same edge. The sync
        // levels here still follow the outgoing mode; the new mode's levels
        // take over from the next edge.
        if (vpg_mode_change) begin
            w_state_nxt  = ST_SETTLE;
            w_settle_nxt = '0;
            w_mode_nxt   = vpg_mode;
            w_h_nxt      = '0;
            w_v_nxt      = '0;
            w_hs_nxt     = ~w_t.h_pol;
            w_vs_nxt     = ~w_t.v_pol;
            w_de_nxt     = 1'b0;
            w_x_nxt      = '0;
            w_y_nxt      = '0;
            w_fs_nxt     = 1'b0;
            w_busy_nxt   = 1'b1;
        end
    end

    assign hs          = r_hs;
    assign vs          = r_vs;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign frame_start = r_fs;
    assign busy        = r_busy;

endmodule

// File: tb/tb_vpg_timing.sv
// Directed bench for vpg_timing with a short settle interval.
module tb_vpg_timing;

    localparam int SETTLE = 4;
    localparam int CNT_W  = 12;

    logic             clk;
    logic             reset_n;
    logic             clk_en;
    logic             vpg_mode_change;
    logic [3:0]       vpg_mode;
    logic             hs;
    logic             vs;
    logic             de;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             frame_start;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    // pos = enabled edges of raster since (0,0) = line*H_TOT + pixel
    typedef struct {
        int mode;
        int pos;
        int de;
        int hs;
        int vs;
        int fs;
        int x;
        int y;
    } vec_t;

    vec_t vecs[31];

    vpg_timing #(
        .SETTLE_CYCLES (SETTLE),
        .CNT_W         (CNT_W)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .clk_en          (clk_en),
        .vpg_mode_change (vpg_mode_change),
        .vpg_mode        (vpg_mode),
        .hs              (hs),
        .vs              (vs),
        .de              (de),
        .x               (x),
        .y               (y),
        .frame_start     (frame_start),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input int mode);
        vpg_mode        = 4'(mode);
        vpg_mode_change = 1'b1;
        tick(1);
        vpg_mode_change = 1'b0;
    endtask

    initial begin
        int de_cnt;
        int hs_lo_cnt;

        // mode, pos, de, hs, vs, fs, x, y
        vecs[0]  = '{0,    0, 1, 1, 1, 1,    0, 0};
        vecs[1]  = '{0,  639, 1, 1, 1, 0,  639, 0};
        vecs[2]  = '{0,  640, 0, 1, 1, 0,    0, 0};
        vecs[3]  = '{0,  655, 0, 1, 1, 0,    0, 0};
        vecs[4]  = '{0,  656, 0, 0, 1, 0,    0, 0};
        vecs[5]  = '{0,  751, 0, 0, 1, 0,    0, 0};
        vecs[6]  = '{0,  752, 0, 1, 1, 0,    0, 0};
        vecs[7]  = '{0,  800, 1, 1, 1, 0,    0, 1};
        vecs[8]  = '{0, 1605, 1, 1, 1, 0,    5, 2};
        vecs[9]  = '{1,  839, 0, 0, 0, 0,    0, 0};
        vecs[10] = '{1,  840, 0, 1, 0, 0,    0, 0};
        vecs[11] = '{1,  967, 0, 1, 0, 0,    0, 0};
        vecs[12] = '{1,  968, 0, 0, 0, 0,    0, 0};
        vecs[13] = '{1, 1059, 1, 0, 0, 0,    3, 1};
        vecs[14] = '{2, 1047, 0, 1, 1, 0,    0, 0};
        vecs[15] = '{2, 1048, 0, 0, 1, 0,    0, 0};
        vecs[16] = '{2, 1184, 0, 1, 1, 0,    0, 0};
        vecs[17] = '{2, 1023, 1, 1, 1, 0, 1023, 0};
        vecs[18] = '{3, 1390, 0, 1, 0, 0,    0, 0};
        vecs[19] = '{3, 1430, 0, 0, 0, 0,    0, 0};
        vecs[20] = '{3, 1651, 1, 0, 0, 0,    1, 1};
        vecs[21] = '{4, 2008, 0, 1, 0, 0,    0, 0};
        vecs[22] = '{4, 2052, 0, 0, 0, 0,    0, 0};
        vecs[23] = '{4, 1919, 1, 0, 0, 0, 1919, 0};
        vecs[24] = '{5, 1663, 0, 0, 0, 0,    0, 0};
        vecs[25] = '{5, 1664, 0, 1, 0, 0,    0, 0};
        vecs[26] = '{5, 1856, 0, 0, 0, 0,    0, 0};
        vecs[27] = '{5, 2160, 1, 0, 0, 0,    0, 1};
        vecs[28] = '{15, 656, 0, 0, 1, 0,    0, 0};
        vecs[29] = '{15, 800, 1, 1, 1, 0,    0, 1};
        vecs[30] = '{15,   0, 1, 1, 1, 1,    0, 0};

        reset_n         = 1'b0;
        clk_en          = 1'b1;
        vpg_mode_change = 1'b0;
        vpg_mode        = 4'h0;
        tick(2);

        // Reset values (default mode has positive syncs -> inactive low)
        check("rst.busy", int'(busy), 1);
        check("rst.de", int'(de), 0);
        check("rst.hs", int'(hs), 0);
        check("rst.vs", int'(vs), 0);
        check("rst.x", int'(x), 0);
        check("rst.y", int'(y), 0);
        check("rst.fs", int'(frame_start), 0);

        // Settle after reset: busy through edge 4, raster visible on edge 5
        reset_n = 1'b1;
        tick(SETTLE);
        check("settle.busy_e4", int'(busy), 1);
        check("settle.de_e4", int'(de), 0);
        tick(1);
        check("settle.busy_e5", int'(busy), 0);
        check("settle.fs_e5", int'(frame_start), 1);
        check("settle.de_e5", int'(de), 1);
        tick(1);
        check("settle.fs_e6", int'(frame_start), 0);
        check("settle.x_e6", int'(x), 1);

        // Table-driven raster probes
        for (int i = 0; i < 31; i++) begin
            strobe(vecs[i].mode);
            tick(SETTLE + 1 + vecs[i].pos);
            check($sformatf("v%0d.de", i), int'(de), vecs[i].de);
            check($sformatf("v%0d.hs", i), int'(hs), vecs[i].hs);
            check($sformatf("v%0d.vs", i), int'(vs), vecs[i].vs);
            check($sformatf("v%0d.fs", i), int'(frame_start), vecs[i].fs);
            check($sformatf("v%0d.x", i), int'(x), vecs[i].x);
            check($sformatf("v%0d.y", i), int'(y), vecs[i].y);
        end

        // VGA line 0: de high 640 cycles, hs low 96 cycles
        strobe(0);
        tick(SETTLE);
        de_cnt    = 0;
        hs_lo_cnt = 0;
        for (int k = 0; k < 800; k++) begin
            tick(1);
            if (de) de_cnt++;
            if (!hs) hs_lo_cnt++;
        end
        check("line.de_count", de_cnt, 640);
        check("line.hs_low_count", hs_lo_cnt, 96);

        // Strobe mid-line at h=300, v=2 of VGA, switching to SVGA
        strobe(0);
        tick(SETTLE + 1900);
        check("mid.x_before", int'(x), 299);
        strobe(1);
        check("mid.de_strobe", int'(de), 0);
        check("mid.busy_strobe", int'(busy), 1);
        check("mid.x_strobe", int'(x), 0);
        tick(SETTLE);
        check("mid.busy_s4", int'(busy), 1);
        tick(1);
        check("mid.busy_s5", int'(busy), 0);
        check("mid.fs_s5", int'(frame_start), 1);
        tick(1056);
        check("mid.new_line_x", int'(x), 0);
        check("mid.new_line_y", int'(y), 1);
        check("mid.new_line_de", int'(de), 1);

        // Second strobe two cycles into settle restarts the interval
        strobe(2);
        tick(1);
        strobe(0);
        tick(3);
        check("restart.busy_s3", int'(busy), 1);
        tick(1);
        check("restart.busy_s4", int'(busy), 1);
        tick(1);
        check("restart.busy_s5", int'(busy), 0);
        check("restart.fs_s5", int'(frame_start), 1);
        tick(656);
        check("restart.hs_vga", int'(hs), 0);
        check("restart.de_vga", int'(de), 0);

        // clk_en gating and ignored strobe while disabled
        strobe(0);
        tick(SETTLE + 1);
        clk_en = 1'b0;
        tick(1);
        check("hold.fs", int'(frame_start), 1);
        check("hold.x", int'(x), 0);
        vpg_mode        = 4'h1;
        vpg_mode_change = 1'b1;
        tick(1);
        vpg_mode_change = 1'b0;
        check("hold.strobe_ignored", int'(busy), 0);
        check("hold.fs2", int'(frame_start), 1);
        for (int k = 0; k < 4; k++) begin
            clk_en = (k % 2 == 0);
            tick(1);
        end
        check("toggle.x2", int'(x), 2);
        for (int k = 4; k < 1600; k++) begin
            clk_en = (k % 2 == 0);
            tick(1);
        end
        check("toggle.line_x", int'(x), 0);
        check("toggle.line_y", int'(y), 1);
        check("toggle.line_de", int'(de), 1);
        check("toggle.busy", int'(busy), 0);
        clk_en = 1'b1;

        // Reset mid-frame clears immediately and restores the default mode
        tick(37);
        check("mrst.de_before", int'(de), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mrst.busy", int'(busy), 1);
        check("mrst.de", int'(de), 0);
        check("mrst.x", int'(x), 0);
        check("mrst.y", int'(y), 0);
        check("mrst.hs", int'(hs), 0);
        tick(1);
        reset_n = 1'b1;
        tick(SETTLE + 1 + 1664);
        check("mrst.default_hs", int'(hs), 1);
        check("mrst.default_de", int'(de), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
